// File: rtl/euler_pkg.sv
// euler_pkg: shared widths, FSM state type and variable indices for the Euler sequencer
package euler_pkg;
  localparam int W  = 18;
  localparam int SW = 16;
  typedef enum logic [2:0] {IDLE, EVAL, UPDATE, CHECK, FIN} fsm_e;
  localparam logic [1:0] VAR_X = 2'd0;
  localparam logic [1:0] VAR_Y = 2'd1;
  localparam logic [1:0] VAR_Z = 2'd2;
endpackage

// File: rtl/euler_sequencer_if.sv
// euler_sequencer_if: control, init, derivative handshake and status bundle of the Euler sequencer
//   master: environment side (drives start/halt/init/dt/num_steps/deriv_valid/deriv)
//   slave : sequencer side (drives var_sel/state_bus/deriv_req/busy/sample_valid/step_count/done)
interface euler_sequencer_if #(parameter int NVARS = 3);
  import euler_pkg::*;
  logic               start;
  logic               halt;
  logic               init_load;
  logic [1:0]         init_idx;
  logic [W-1:0]       init_val;
  logic [3:0]         dt;
  logic [SW-1:0]      num_steps;
  logic [1:0]         var_sel;
  logic [NVARS*W-1:0] state_bus;
  logic               deriv_req;
  logic               deriv_valid;
  logic [W-1:0]       deriv;
  logic               busy;
  logic               sample_valid;
  logic [SW-1:0]      step_count;
  logic               done;
  modport master (
    output start, halt, init_load, init_idx, init_val, dt, num_steps, deriv_valid, deriv,
    input  var_sel, state_bus, deriv_req, busy, sample_valid, step_count, done
  );
  modport slave (
    input  start, halt, init_load, init_idx, init_val, dt, num_steps, deriv_valid, deriv,
    output var_sel, state_bus, deriv_req, busy, sample_valid, step_count, done
  );
endinterface

// File: rtl/euler_sequencer_integrator.sv
// euler_sequencer_integrator: combinational Euler update xnew = x + (func >>> dt), wrapping
//   x_i    current state value
//   func_i derivative value
//   dt_i   step size as arithmetic right-shift count
//   xnew_o updated state value
module euler_sequencer_integrator
  import euler_pkg::*;
(
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] func_i,
  input  logic        [3:0]   dt_i,
  output logic signed [W-1:0] xnew_o
);
  assign xnew_o = x_i + (func_i >>> dt_i);
endmodule

// File: rtl/euler_sequencer.sv
// euler_sequencer: fixed-step Euler integration of NVARS variables through one shared integrator
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : start/halt/init/dt/num_steps in, derivative req/valid handshake,
//                  state snapshot, busy, sample_valid, step_count and done out
module euler_sequencer
  import euler_pkg::*;
#(
  parameter int NVARS = 3
) (
  input logic clock,
  input logic reset,
  euler_sequencer_if.slave bus
);
  fsm_e               fsm_q, fsm_d;
  logic signed [W-1:0] state_q [NVARS];
  logic signed [W-1:0] d_q [NVARS];
  logic [1:0]          idx_q;
  logic [3:0]          dt_q;
  logic [SW-1:0]       num_q;
  logic [SW-1:0]       step_q;
  logic                sv_q;
  logic signed [W-1:0] xnew;
  logic                last;
  assign last = idx_q == 2'(NVARS - 1);
  // idx_q walks the variables in both EVAL and UPDATE, so it also steers the integrator mux
  euler_sequencer_integrator u_int (
    .x_i   (state_q[idx_q]),
    .func_i(d_q[idx_q]),
    .dt_i  (dt_q),
    .xnew_o(xnew)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) fsm_q <= IDLE;
    else fsm_q <= fsm_d;
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    fsm_d = bus.start ? CHECK : IDLE;
      EVAL:    fsm_d = (bus.deriv_valid && last) ? UPDATE : EVAL;
      UPDATE:  fsm_d = last ? CHECK : UPDATE;
      CHECK:   fsm_d = (step_q == num_q || bus.halt) ? FIN : EVAL;
      default: fsm_d = IDLE;
    endcase
  end
  // step_q is bumped on the edge into CHECK so the count is already current while sample_valid is high
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < NVARS; i++) begin
        state_q[i] <= '0;
        d_q[i]     <= '0;
      end
      idx_q  <= VAR_X;
      dt_q   <= '0;
      num_q  <= '0;
      step_q <= '0;
      sv_q   <= 1'b0;
    end else begin
      sv_q <= fsm_q == UPDATE && last;
      case (fsm_q)
        IDLE: begin
          if (bus.init_load && int'(bus.init_idx) < NVARS) state_q[bus.init_idx] <= bus.init_val;
          if (bus.start) begin
            dt_q   <= bus.dt;
            num_q  <= bus.num_steps;
            step_q <= '0;
          end
        end
        EVAL:
          if (bus.deriv_valid) begin
            d_q[idx_q] <= bus.deriv;
            idx_q      <= last ? VAR_X : idx_q + 2'd1;
          end
        UPDATE: begin
          state_q[idx_q] <= xnew;
          idx_q          <= last ? VAR_X : idx_q + 2'd1;
          if (last) step_q <= step_q + SW'(1);
        end
        default: ;
      endcase
    end
  for (genvar g = 0; g < NVARS; g++) begin : g_bus
    assign bus.state_bus[g*W +: W] = state_q[g];
  end
  assign bus.var_sel      = idx_q;
  assign bus.deriv_req    = fsm_q == EVAL;
  assign bus.busy         = fsm_q != IDLE;
  assign bus.sample_valid = sv_q;
  assign bus.step_count   = step_q;
  assign bus.done         = fsm_q == FIN;
endmodule
